cvxif_resp_unit: RTL and testbench

Coprocessor-side responder for the CoreV-X-Interface: accepts offloaded instructions from the core's CVXIF functional unit, decodes a small custom-3 instruction set, executes it in a fixed-latency pipeline and returns results in issue order through a result FIFO. It sits in the subsystem outside the core, driving `cvxif_resp_t` and consuming `cvxif_req_t`. It serves as the reference coprocessor for bring-up and as the responder in CVXIF verification environments.

---
 rtl/cvxif_resp_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_cvxif_resp_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_resp_unit.sv
// rtl/cvxif_resp_unit.sv - CVXIF reference coprocessor: custom-3 decode, fixed-latency execute, in-order result FIFO
package cvxif_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned X_NUM_RS   = 2;
    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [15:0] instr;
        logic [1:0]  mode;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                      instr;
        logic [1:0]                       mode;
        logic [X_ID_WIDTH-1:0]            id;
        logic [X_NUM_RS-1:0][XLEN-1:0]    rs;
        logic [X_NUM_RS-1:0]              rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       addr;
        logic                  we;
        logic [XLEN-1:0]       wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       rdata;
        logic                  err;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        x_mem_resp_t       x_mem_resp;
        logic              x_mem_result_valid;
        x_mem_result_t     x_mem_result;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;
endpackage

module cvxif_resp_unit
    import cvxif_pkg::*;
#(
    parameter int unsigned Latency   = 2,
    parameter int unsigned FifoDepth = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  cvxif_req_t  cvxif_req_i,
    output cvxif_resp_t cvxif_resp_o
);
    localparam int unsigned   PW     = $clog2(FifoDepth);
    localparam int unsigned   CW     = $clog2(FifoDepth + 1);
    localparam logic [CW-1:0] DepthC = CW'(FifoDepth);
    localparam logic [PW:0]   PtrOne = (PW + 1)'(1);

    typedef struct packed {
        logic      valid;
        logic      killed;
        x_result_t res;
    } pipe_entry_t;

    x_issue_req_t    issue_req;
    logic [XLEN-1:0] rs0, rs1, rs2;

    assign issue_req = cvxif_req_i.x_issue_req;
    assign rs0       = issue_req.rs[0];
    assign rs1       = issue_req.rs[1];

    generate
        if (X_NUM_RS >= 3) begin : g_rs2
            assign rs2 = issue_req.rs[2];
        end else begin : g_no_rs2
            assign rs2 = '0;
        end
    endgenerate

    logic            dec_accept, dec_we, dec_exc;
    logic [5:0]      dec_exccode;
    logic [XLEN-1:0] dec_data;

    always_comb begin
        dec_accept  = 1'b0;
        dec_we      = 1'b0;
        dec_exc     = 1'b0;
        dec_exccode = '0;
        dec_data    = '0;
        if (issue_req.instr[6:0] == 7'b1111011) begin
            case (issue_req.instr[14:12])
                3'b000: begin dec_accept = 1'b1; dec_we = 1'b1; dec_data = rs0 + rs1; end
                3'b001: begin dec_accept = 1'b1; dec_we = 1'b1; dec_data = rs0 - rs1; end
                3'b010: begin dec_accept = 1'b1; dec_we = 1'b1; dec_data = rs0 ^ rs1; end
                3'b011: begin
                    dec_accept = (X_NUM_RS == 3);
                    dec_we     = (X_NUM_RS == 3);
                    dec_data   = rs0 + rs1 + rs2;
                end
                3'b100: dec_accept = 1'b1;
                3'b101: begin dec_accept = 1'b1; dec_exc = 1'b1; dec_exccode = 6'd2; end
                default: dec_accept = 1'b0;
            endcase
        end
    end

    logic                  kill_en;
    logic [X_ID_WIDTH-1:0] kill_id;
    logic [CW-1:0]         count_q, count_d;
    logic                  issue_ready, issue_fire;

    assign kill_en     = cvxif_req_i.x_commit_valid && cvxif_req_i.x_commit.x_commit_kill;
    assign kill_id     = cvxif_req_i.x_commit.id;
    assign issue_ready = !rst_i && !clear_i && (count_q < DepthC);
    assign issue_fire  = cvxif_req_i.x_issue_valid && issue_ready && dec_accept;

    pipe_entry_t pipe_q [Latency];
    pipe_entry_t pipe_d [Latency];

    // Stages always advance; the occupancy counter guarantees a FIFO slot for every live entry.
    always_comb begin
        pipe_d[0].valid  = issue_fire;
        pipe_d[0].killed = kill_en && (issue_req.id == kill_id);
        pipe_d[0].res    = '{id: issue_req.id, data: dec_data, rd: issue_req.instr[11:7],
                             we: dec_we, exc: dec_exc, exccode: dec_exccode};
        for (int i = 1; i < Latency; i++) begin
            pipe_d[i]        = pipe_q[i-1];
            pipe_d[i].killed = pipe_q[i-1].killed || (kill_en && (pipe_q[i-1].res.id == kill_id));
        end
    end

    pipe_entry_t last;
    logic        last_killed, fifo_push, kill_retire, fifo_valid, fifo_pop;
    logic [PW:0] wptr_q, rptr_q;
    x_result_t   mem_q [FifoDepth];

    assign last        = pipe_q[Latency-1];
    assign last_killed = last.killed || (kill_en && (last.res.id == kill_id));
    assign fifo_push   = last.valid && !last_killed;
    assign kill_retire = last.valid && last_killed;
    assign fifo_valid  = (wptr_q != rptr_q);
    assign fifo_pop    = fifo_valid && cvxif_req_i.x_result_ready;
    assign count_d     = count_q + CW'(issue_fire) - CW'(fifo_pop) - CW'(kill_retire);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < Latency; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            if (fifo_push) wptr_q <= wptr_q + PtrOne;
            if (fifo_pop)  rptr_q <= rptr_q + PtrOne;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) mem_q[wptr_q[PW-1:0]] <= last.res;
    end

    always_comb begin
        cvxif_resp_o                        = '0;
        cvxif_resp_o.x_compressed_ready     = 1'b1;
        cvxif_resp_o.x_issue_ready          = issue_ready;
        cvxif_resp_o.x_issue_resp.accept    = dec_accept;
        cvxif_resp_o.x_issue_resp.writeback = dec_we;
        cvxif_resp_o.x_issue_resp.exc       = dec_exc;
        cvxif_resp_o.x_result_valid         = fifo_valid;
        cvxif_resp_o.x_result               = fifo_valid ? mem_q[rptr_q[PW-1:0]] : '0;
    end

    logic unused_req;
    assign unused_req = ^{cvxif_req_i.x_compressed_valid, cvxif_req_i.x_compressed_req,
                          issue_req.mode, issue_req.rs_valid, issue_req.instr[31:15],
                          cvxif_req_i.x_mem_ready, cvxif_req_i.x_mem_resp,
                          cvxif_req_i.x_mem_result_valid, cvxif_req_i.x_mem_result};
endmodule

// File: tb/tb_cvxif_resp_unit.sv
// tb/tb_cvxif_resp_unit.sv - scoreboard bench for cvxif_resp_unit
module tb_cvxif_resp_unit;
    import cvxif_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [6:0] OP = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    cvxif_req_t  req;
    cvxif_resp_t resp;

    always #5 clk = ~clk;

    cvxif_resp_unit #(.Latency(LAT), .FifoDepth(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .cvxif_req_i (req),
        .cvxif_resp_o(resp)
    );

    int        errors = 0;
    int        checks = 0;
    int        n_pops = 0;
    x_result_t exp_q[$];
    x_result_t mon_e;
    logic      rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd,
                                     input logic we, input logic exc, input logic [5:0] ec);
        x_result_t r;
        r.id = id; r.data = d; r.rd = rd; r.we = we; r.exc = exc; r.exccode = ec;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && !clear && resp.x_result_valid && req.x_result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id %0d data %h expected none",
                         resp.x_result.id, resp.x_result.data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 64'(resp.x_result), 64'(mon_e));
            end
            n_pops++;
        end
    end

    task automatic drive_idle;
        req.x_issue_valid  = 1'b0;
        req.x_commit_valid = 1'b0;
        req.x_commit       = '0;
    endtask

    task automatic issue1(input logic [3:0] id, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic kill, input logic [3:0] kid, input logic exp_acc,
                          input x_result_t exp_r, input logic push, output logic xfer);
        @(posedge clk); #1;
        req.x_issue_valid            = 1'b1;
        req.x_issue_req.id           = id;
        req.x_issue_req.instr        = {17'b0, f3, rd, op};
        req.x_issue_req.rs[0]        = a;
        req.x_issue_req.rs[1]        = b;
        req.x_commit_valid           = kill;
        req.x_commit.id              = kid;
        req.x_commit.x_commit_kill   = kill;
        if (rand_rdy) req.x_result_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("issue_accept", resp.x_issue_resp.accept, exp_acc);
        if (exp_acc) begin
            chk("issue_writeback", resp.x_issue_resp.writeback, exp_r.we);
            chk("issue_exc", resp.x_issue_resp.exc, exp_r.exc);
        end
        xfer = resp.x_issue_ready && resp.x_issue_resp.accept;
        if (xfer && push) exp_q.push_back(exp_r);
    endtask

    task automatic flush_test(input logic use_clear);
        logic x;
        int   p0;
        @(posedge clk); #1;
        req.x_result_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue1(4'(i), OP, 3'b000, 32'(i), 32'd1, 5'd1, 1'b0, 4'd0, 1'b1,
                   mk(4'(i), 32'(i + 1), 5'd1, 1'b1, 1'b0, 6'd0), 1'b1, x);
        @(posedge clk); #1;
        drive_idle();
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush_issue_ready_low", resp.x_issue_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear = 1'b0;
        req.x_result_ready = 1'b1;
        p0 = n_pops;
        @(negedge clk);
        chk("flush_issue_ready_next", resp.x_issue_ready, 1'b1);
        chk("flush_result_valid", resp.x_result_valid, 1'b0);
        repeat (6) @(negedge clk);
        chk("flush_no_stale", 64'(n_pops - p0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic x;
        int   n_acc;
        int   p0;
        int   tries;
        req   = '0;
        rst   = 1'b1;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_issue_ready", resp.x_issue_ready, 1'b0);
        chk("reset_result_valid", resp.x_result_valid, 1'b0);
        chk("reset_result", 64'(resp.x_result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", resp.x_issue_ready, 1'b1);
        chk("valid_after_reset", resp.x_result_valid, 1'b0);

        // ADD latency: issue at T, result visible at T+LAT+1
        issue1(4'd3, OP, 3'b000, 32'd5, 32'd7, 5'd10, 1'b0, 4'd0, 1'b1,
               mk(4'd3, 32'd12, 5'd10, 1'b1, 1'b0, 6'd0), 1'b1, x);
        chk("add_xfer", x, 1'b1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("add_valid_t1", resp.x_result_valid, 1'b0);
        @(negedge clk);
        chk("add_valid_t2", resp.x_result_valid, 1'b0);
        @(negedge clk);
        chk("add_valid_t3", resp.x_result_valid, 1'b1);
        @(posedge clk); #1;
        req.x_result_ready = 1'b1;

        issue1(4'd1, OP, 3'b001, 32'd0, 32'd1, 5'd2, 1'b0, 4'd0, 1'b1,
               mk(4'd1, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 6'd0), 1'b1, x);
        issue1(4'd2, OP, 3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 5'd3, 1'b0, 4'd0, 1'b1,
               mk(4'd2, 32'h0000_FF00, 5'd3, 1'b1, 1'b0, 6'd0), 1'b1, x);
        issue1(4'd4, OP, 3'b101, 32'd9, 32'd9, 5'd5, 1'b0, 4'd0, 1'b1,
               mk(4'd4, 32'd0, 5'd5, 1'b0, 1'b1, 6'd2), 1'b1, x);
        issue1(4'd7, OP, 3'b100, 32'd1, 32'd1, 5'd4, 1'b0, 4'd0, 1'b1,
               mk(4'd7, 32'd0, 5'd4, 1'b0, 1'b0, 6'd0), 1'b1, x);
        issue1(4'd8, OP, 3'b111, 32'd1, 32'd1, 5'd6, 1'b0, 4'd0, 1'b0, '0, 1'b0, x);
        issue1(4'd8, OP, 3'b011, 32'd1, 32'd2, 5'd6, 1'b0, 4'd0, 1'b0, '0, 1'b0, x);
        issue1(4'd8, 7'b0110011, 3'b000, 32'd1, 32'd2, 5'd6, 1'b0, 4'd0, 1'b0, '0, 1'b0, x);
        @(posedge clk); #1;
        drive_idle();
        repeat (6) @(negedge clk);
        chk("directed_drained_valid", resp.x_result_valid, 1'b0);
        chk("directed_queue_empty", 64'(exp_q.size()), 64'd0);

        // same-cycle kill, neighbour survives, then kill of an in-flight entry
        issue1(4'd5, OP, 3'b000, 32'd1, 32'd1, 5'd1, 1'b1, 4'd5, 1'b1,
               mk(4'd5, 32'd2, 5'd1, 1'b1, 1'b0, 6'd0), 1'b0, x);
        issue1(4'd6, OP, 3'b000, 32'd1, 32'd2, 5'd1, 1'b0, 4'd0, 1'b1,
               mk(4'd6, 32'd3, 5'd1, 1'b1, 1'b0, 6'd0), 1'b1, x);
        issue1(4'd8, OP, 3'b000, 32'd2, 32'd2, 5'd1, 1'b0, 4'd0, 1'b1,
               mk(4'd8, 32'd4, 5'd1, 1'b1, 1'b0, 6'd0), 1'b0, x);
        issue1(4'd9, OP, 3'b000, 32'd3, 32'd4, 5'd2, 1'b1, 4'd8, 1'b1,
               mk(4'd9, 32'd7, 5'd2, 1'b1, 1'b0, 6'd0), 1'b1, x);
        @(posedge clk); #1;
        drive_idle();
        repeat (6) @(negedge clk);
        chk("kill_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("kill_drained_valid", resp.x_result_valid, 1'b0);

        flush_test(1'b0);
        flush_test(1'b1);

        // backpressure: exactly DEPTH accepted with no drain; also proves count returned to 0
        @(posedge clk); #1;
        req.x_result_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue1(4'(10 + i), OP, 3'b000, 32'(i), 32'd100, 5'd3, 1'b0, 4'd0, 1'b1,
                   mk(4'(10 + i), 32'(i + 100), 5'd3, 1'b1, 1'b0, 6'd0), 1'b1, x);
            n_acc += int'(x);
        end
        chk("bp_accepted", 64'(n_acc), 64'd4);
        chk("bp_issue_ready_low", resp.x_issue_ready, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        req.x_result_ready = 1'b1;
        p0 = n_pops;
        @(negedge clk);
        chk("bp_ready_pop_cycle", resp.x_issue_ready, 1'b0);
        @(negedge clk);
        chk("bp_ready_after_pop", resp.x_issue_ready, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        chk("bp_pops_back_to_back", 64'(n_pops - p0), 64'd4);

        // pointer wrap under random result backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x = 1'b0;
            tries = 0;
            while (!x && tries < 50) begin
                issue1(4'(i % 16), OP, 3'b000, 32'(i * 7), 32'hFFFF_FFF0, 5'(i % 32), 1'b0, 4'd0, 1'b1,
                       mk(4'(i % 16), 32'(i * 7) + 32'hFFFF_FFF0, 5'(i % 32), 1'b1, 1'b0, 6'd0), 1'b1, x);
                tries++;
            end
            if (!x) chk("wrap_issue_timeout", 64'(tries), 64'd0);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        drive_idle();
        req.x_result_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("wrap_final_valid", resp.x_result_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
